dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory (word array, 9-bit byte address, 32-bit data, level-sensitive MemRead/MemWrite strobes).
- Requester 0 is the core load/store unit. Requester 1 is the debug/loader port.
- Grants one access at a time, drives registered memory strobes for exactly one cycle, captures read data, and returns a one-cycle ack.
- Fixed priority to requester 0, with a starvation limit that guarantees progress for requester 1.

---
 rtl/dmem_arb_pkg.sv | 25 ++
 rtl/dmem_arb_pick.sv | 38 +++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// States, requester ids, default widths and the word-alignment helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_e;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    // Wide enough for the whole legal MAX_WAIT range (1..15)
    localparam int WAIT_W = 4;

    // True when a byte address does not point at the start of a word
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection and next starvation-counter value.
// Requester 0 wins by default; requester 1 wins when requester 0 is idle
// or once it has lost MAX_WAIT consecutive arbitrations.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              i_r0_req,
    input  logic              i_r1_req,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    output logic              o_any,
    output logic              o_grant,
    output logic [WAIT_W-1:0] o_wait_nxt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    // Pick the winner and work out how long requester 1 has been waiting
    always_comb begin
        o_any      = i_r0_req | i_r1_req;
        o_grant    = REQ_CORE;
        o_wait_nxt = i_wait_cnt;
        if (i_r1_req && (!i_r0_req || (i_wait_cnt == MAX_WAIT_C))) begin
            o_grant = REQ_DBG;
        end else begin
            o_grant = REQ_CORE;
        end
        if (!i_r1_req || (o_grant == REQ_DBG)) begin
            o_wait_nxt = 4'd0;
        end else if (i_wait_cnt >= MAX_WAIT_C) begin
            o_wait_nxt = MAX_WAIT_C;
        end else begin
            o_wait_nxt = i_wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port data memory.
// One access at a time: IDLE -> ACCESS (one strobe cycle) -> ACK (one ack cycle).
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN adds r0_err/r1_err and
// completes misaligned requests without touching memory.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic              r0_err,
    output logic              r1_err,
`endif
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_any;
    logic              w_grant;
    logic              r_gnt;
    logic              r_we;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    logic              w_misalign;

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .i_r0_req   (r0_req),
        .i_r1_req   (r1_req),
        .i_wait_cnt (r_wait_cnt),
        .o_any      (w_any),
        .o_grant    (w_grant),
        .o_wait_nxt (w_wait_nxt)
    );

    // Route the winning requester's command fields
    always_comb begin
        w_win_we    = r0_we;
        w_win_addr  = r0_addr;
        w_win_wdata = r0_wdata;
        if (w_grant == REQ_DBG) begin
            w_win_we    = r1_we;
            w_win_addr  = r1_addr;
            w_win_wdata = r1_wdata;
        end else begin
            w_win_we    = r0_we;
            w_win_addr  = r0_addr;
            w_win_wdata = r0_wdata;
        end
    end

    // Misaligned requests bypass memory only when alignment checking is built in
    always_comb begin
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        w_misalign = addr_misaligned(w_win_addr[1:0]);
`else
        w_misalign = 1'b0;
`endif
    end

    // Next-state logic of the access sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = w_misalign ? ACK : ACCESS;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACCESS:  w_state_nxt = ACK;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered grant, strobes, memory command, acks and returned data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt   <= 4'd0;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_rdata     <= {DATA_W{1'b0}};
            r1_rdata     <= {DATA_W{1'b0}};
            busy         <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            r0_err       <= 1'b0;
            r1_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= w_wait_nxt;
                    if (w_any) begin
                        r_gnt <= w_grant;
                        r_we  <= w_win_we;
                        busy  <= 1'b1;
                        if (w_misalign) begin
                            // Complete at once with an error and no memory traffic
                            if (w_grant == REQ_DBG) begin
                                r1_ack   <= 1'b1;
                                r1_rdata <= {DATA_W{1'b0}};
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                                r1_err   <= 1'b1;
`endif
                            end else begin
                                r0_ack   <= 1'b1;
                                r0_rdata <= {DATA_W{1'b0}};
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                                r0_err   <= 1'b1;
`endif
                            end
                        end else begin
                            mem_MemWrite <= w_win_we;
                            mem_MemRead  <= ~w_win_we;
                            mem_addr     <= w_win_addr;
                            mem_wdata    <= w_win_wdata;
                        end
                    end
                end
                ACCESS: begin
                    mem_MemRead  <= 1'b0;
                    mem_MemWrite <= 1'b0;
                    if (r_gnt == REQ_DBG) begin
                        r1_ack   <= 1'b1;
                        r1_rdata <= r_we ? {DATA_W{1'b0}} : mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                        r1_err   <= 1'b0;
`endif
                    end else begin
                        r0_ack   <= 1'b1;
                        r0_rdata <= r_we ? {DATA_W{1'b0}} : mem_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                        r0_err   <= 1'b0;
`endif
                    end
                end
                ACK: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    mem_MemRead  <= 1'b0;
                    mem_MemWrite <= 1'b0;
                    r0_ack       <= 1'b0;
                    r1_ack       <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// arbitration/reset sequences, and randomized two-requester traffic scored
// against a word-array memory image.
module tb_dmem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [8:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_ack, r1_ack;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_MemRead, mem_MemWrite;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic        r0_err, r1_err;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic mon_en = 1'b0;

    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        .r0_err(r0_err), .r1_err(r1_err),
`endif
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Memory: level-sensitive strobes, word array, low address bits ignored
    always @(posedge clk) if (mem_MemWrite) mem[mem_addr[8:2]] <= mem_wdata;
    assign mem_rdata = mem_MemRead ? mem[mem_addr[8:2]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Invariants observed every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            chk("strobe_excl", {31'd0, mem_MemRead & mem_MemWrite}, 32'd0);
            chk("ack_excl", {31'd0, r0_ack & r1_ack}, 32'd0);
            chk("strobe_busy", {31'd0, (mem_MemRead | mem_MemWrite) & ~busy}, 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One access from one requester, starting and ending with the DUT idle
    task automatic xfer(input int port, input logic we, input logic [8:0] addr,
                        input logic [31:0] wd, input int exp_lat, output logic [31:0] rd);
        int  cyc;
        int  strb;
        logic got;
        logic mis;
        mis = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`endif
        if (port == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end
        cyc = 0; strb = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (mem_MemRead | mem_MemWrite) begin
                strb++;
                chk("strobe_kind", {30'd0, mem_MemWrite, mem_MemRead}, {30'd0, we, ~we});
                chk("mem_addr", {23'd0, mem_addr}, {23'd0, addr});
                if (we) chk("mem_wdata", mem_wdata, wd);
            end
            if ((port == 0 && r0_ack) || (port == 1 && r1_ack)) got = 1'b1;
        end
        chk("ack_latency", cyc, exp_lat);
        chk("strobe_cycles", strb, mis ? 0 : 1);
        chk("other_ack_low", {31'd0, port == 0 ? r1_ack : r0_ack}, 32'd0);
        rd = (port == 0) ? r0_rdata : r1_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        chk("err_flag", {31'd0, port == 0 ? r0_err : r1_err}, {31'd0, mis});
`endif
        if (got && we && !mis) ref_mem[addr[8:2]] = wd;
        r0_req = 1'b0; r1_req = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", {30'd0, r0_ack, r1_ack}, 32'd0);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] rd;
    int          cnt;
    logic        seen;

    // Randomized traffic state, one slot per requester
    logic        pend [2];
    logic        p_we [2];
    logic [8:0]  p_addr [2];
    logic [31:0] p_wd [2];
    int          age [2];

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst_n = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 9'h0; r0_wdata = 32'h0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 9'h0; r1_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {26'd0, mem_MemRead, mem_MemWrite, r0_ack, r1_ack, busy, 1'b0}, 32'd0);
        chk("rst_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_rdata", r0_rdata | r1_rdata | mem_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed vectors
        tbl[0] = '{0, 1'b1, 9'h010, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1, 1'b1, 9'h1FC, 32'h12345678, 32'h0};
        tbl[3] = '{0, 1'b0, 9'h1FC, 32'h0,        32'h12345678};
        tbl[4] = '{1, 1'b0, 9'h000, 32'h0,        32'h0};
        tbl[5] = '{1, 1'b1, 9'h014, 32'hA5A5F00F, 32'h0};
        tbl[6] = '{1, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF};
        tbl[7] = '{0, 1'b0, 9'h014, 32'h0,        32'hA5A5F00F};
        for (int i = 0; i < 8; i++) begin
            xfer(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, 2, rd);
            chk("vec_rdata", rd, tbl[i].exp);
        end

        // Simultaneous requests: requester 0 must complete first
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h010;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 9'h1FC;
        cnt = 0;
        while (!(r0_ack | r1_ack) && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("tie_first_r0", {30'd0, r0_ack, r1_ack}, 32'd2);
        chk("tie_r0_rdata", r0_rdata, ref_mem[9'h010 >> 2]);
        r0_req = 1'b0;
        cnt = 0;
        while (!r1_ack && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("tie_r1_ack", {31'd0, r1_ack}, 32'd1);
        chk("tie_r1_rdata", r1_rdata, ref_mem[9'h1FC >> 2]);
        r1_req = 1'b0;
        @(posedge clk); #1;

        // Starvation limit: with r0 always requesting, r1 gets every (MAXW+1)-th grant
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 9'h010;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 9'h014;
        for (int round = 0; round < 2; round++) begin
            cnt = 0; seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(posedge clk); #1;
                if (r0_ack) cnt++;
                if (r1_ack) seen = 1'b1;
            end
            chk("starve_r1_served", {31'd0, seen}, 32'd1);
            chk("starve_r0_wins", cnt, MAXW);
            chk("starve_r1_rdata", r1_rdata, ref_mem[9'h014 >> 2]);
        end
        r0_req = 1'b0; r1_req = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a write
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 9'h020; r0_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("rstmid_strobe", {31'd0, mem_MemWrite}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ctrl", {27'd0, mem_MemRead, mem_MemWrite, r0_ack, r1_ack, busy}, 32'd0);
        chk("rstmid_addr", {23'd0, mem_addr}, 32'd0);
        chk("rstmid_data", r0_rdata | r1_rdata | mem_wdata, 32'd0);
        r0_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rstmid_no_ack", {30'd0, r0_ack, r1_ack}, 32'd0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 1'b0, 9'h020, 32'h0, 2, rd);
        chk("rstmid_after", rd, ref_mem[9'h020 >> 2]);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        // Misaligned request completes straight away with an error
        xfer(1, 1'b0, 9'h013, 32'h0, 1, rd);
        chk("misalign_rdata", rd, 32'h0);
        xfer(0, 1'b1, 9'h011, 32'h55555555, 1, rd);
        xfer(0, 1'b0, 9'h010, 32'h0, 2, rd);
        chk("misalign_no_write", rd, 32'hDEADBEEF);
`endif

        // Randomized interleaved traffic
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = 9'h0; p_wd[p] = 32'h0; age[p] = 0;
        end
        for (int c = 0; c < 10100; c++) begin
            if (c >= 10000 && !pend[0] && !pend[1]) break;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? r0_ack : r1_ack) begin
                    chk("rand_ack_expected", {31'd0, pend[p]}, 32'd1);
                    if (pend[p]) begin
                        if (p_we[p]) begin
                            ref_mem[p_addr[p][8:2]] = p_wd[p];
                            chk("rand_wr_rdata", (p == 0) ? r0_rdata : r1_rdata, 32'h0);
                        end else begin
                            chk("rand_rd_rdata", (p == 0) ? r0_rdata : r1_rdata,
                                ref_mem[p_addr[p][8:2]]);
                        end
                    end
                    pend[p] = 1'b0;
                end else if (pend[p]) begin
                    age[p]++;
                    if (age[p] > 40) begin
                        chk("rand_timeout", 32'd0, 32'd1);
                        pend[p] = 1'b0;
                    end
                end
                if (!pend[p] && c < 10000 && $urandom_range(0, 3) != 0) begin
                    pend[p]   = 1'b1;
                    p_we[p]   = 1'($urandom_range(0, 1));
                    p_addr[p] = {7'($urandom_range(0, 127)), 2'b00};
                    p_wd[p]   = $urandom;
                    age[p]    = 0;
                end
            end
            r0_req = pend[0]; r0_we = p_we[0]; r0_addr = p_addr[0]; r0_wdata = p_wd[0];
            r1_req = pend[1]; r1_we = p_we[1]; r1_addr = p_addr[1]; r1_wdata = p_wd[1];
        end
        chk("rand_drained", {30'd0, pend[0], pend[1]}, 32'd0);
        r0_req = 1'b0; r1_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("end_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
